// File: rtl/xnor_decode_sequencer.sv
// xnor_decode_sequencer
// Frame controller around a two-register XNOR transition decoder.
// A parallel word is accepted in IDLE, shifted MSB-first through the
// decoder (Q0 = history, Q1 = decoded bit), the decoded bits are collected
// into an accumulator, and the finished word is offered on a valid/ready
// output port until the consumer takes it.
module xnor_decode_sequencer #(
  parameter int   WIDTH = 8,
  parameter logic SEED  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ser_din
);

  // Counter must be able to hold WIDTH-1 for every legal WIDTH (2..32).
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] out_data_r;
  logic [CNT_W-1:0] cnt_r;
  logic             q0_r;
  logic             q1_r;

  logic             in_ready_s;
  logic             out_valid_s;
  logic             busy_s;
  logic             ser_din_s;

  // FSM state register; reset always wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode from the current state and the two handshake inputs.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        // The edge taken while the counter holds WIDTH-1 is the last shift.
        if (cnt_r == LAST_CNT) begin
          state_s = DRAIN;
        end else begin
          state_s = SHIFT;
        end
      end
      DRAIN: begin
        state_s = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Port outputs decoded purely from state (plus the shift register MSB),
  // so no combinational path exists from in_valid/out_ready to an output.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    ser_din_s   = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
      end
      SHIFT: begin
        busy_s    = 1'b1;
        ser_din_s = shift_r[WIDTH-1];
      end
      DRAIN: begin
        busy_s = 1'b1;
      end
      HOLD: begin
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Datapath: frame load, serial decode, bit collection and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r    <= {WIDTH{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      out_data_r <= {WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      q0_r       <= 1'b0;
      q1_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            shift_r <= in_data;
            q0_r    <= SEED;
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
          end
        end
        SHIFT: begin
          shift_r <= {shift_r[WIDTH-2:0], 1'b0};
          q1_r    <= ~(q0_r ^ shift_r[WIDTH-1]);
          q0_r    <= shift_r[WIDTH-1];
          cnt_r   <= cnt_r + CNT_W'(1);
          // Q1 only holds a real decoded bit after the first shift edge.
          if (cnt_r != {CNT_W{1'b0}}) begin
            acc_r <= {acc_r[WIDTH-2:0], q1_r};
          end
        end
        DRAIN: begin
          // Decoder registers hold; fold in the last decoded bit.
          acc_r      <= {acc_r[WIDTH-2:0], q1_r};
          out_data_r <= {acc_r[WIDTH-2:0], q1_r};
        end
        HOLD: begin
          shift_r <= shift_r;
        end
        default: begin
          shift_r <= shift_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign busy      = busy_s;
  assign ser_din   = ser_din_s;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_xnor_decode_sequencer.sv
// Directed testbench for xnor_decode_sequencer: one SEED=1 instance for the
// main scenarios and one SEED=0 instance for the alternate seed.
module tb_xnor_decode_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       ser_din;

  logic [7:0] in_data0;
  logic       in_valid0;
  logic       in_ready0;
  logic [7:0] out_data0;
  logic       out_valid0;
  logic       out_ready0;
  logic       busy0;
  logic       ser_din0;

  int tests_run;
  int tests_failed;

  xnor_decode_sequencer #(.WIDTH(8), .SEED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .ser_din(ser_din)
  );

  xnor_decode_sequencer #(.WIDTH(8), .SEED(1'b0)) dut_seed0 (
    .clk(clk), .rst(rst),
    .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .busy(busy0), .ser_din(ser_din0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame on the SEED=1 instance; hold_cycles>0 applies backpressure.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] exp,
                           input string tag, input int hold_cycles);
    int n;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = (hold_cycles == 0);
    check_eq({tag, "_in_ready_idle"}, in_ready, 1);
    step();                       // E0: accept
    in_valid = 1'b0;
    in_data  = ~d;                // must not disturb the frame in flight
    check_eq({tag, "_busy"}, busy, 1);
    check_eq({tag, "_in_ready_busy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      if (n < 8) begin
        check_eq($sformatf("%s_ser_din%0d", tag, n), ser_din, d[7-n]);
      end
      step();
      n++;
    end
    check_eq({tag, "_latency"}, n, 9);
    check_eq({tag, "_out_data"}, out_data, exp);
    for (int i = 0; i < hold_cycles; i++) begin
      check_eq({tag, "_hold_valid"}, out_valid, 1);
      check_eq({tag, "_hold_data"}, out_data, exp);
      check_eq({tag, "_hold_in_ready"}, in_ready, 0);
      in_data  = 8'h55;
      in_valid = (i == 5);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();                       // handshake edge
    check_eq({tag, "_valid_drop"}, out_valid, 0);
    check_eq({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  // One frame on the SEED=0 instance.
  task automatic run_frame0(input logic [7:0] d, input logic [7:0] exp, input string tag);
    int n;
    in_data0   = d;
    in_valid0  = 1'b1;
    out_ready0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    n = 0;
    while (!out_valid0 && n < 40) begin
      step();
      n++;
    end
    check_eq({tag, "_latency"}, n, 9);
    check_eq({tag, "_out_data"}, out_data0, exp);
    step();
    check_eq({tag, "_in_ready_back"}, in_ready0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         acc_e[$];
    logic [7:0] outs[$];

    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in_data0   = 8'h00;
    in_valid0  = 1'b0;
    out_ready0 = 1'b1;

    // Reset state
    step();
    step();
    rst = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ser_din", ser_din, 0);
    check_eq("rst_out_data", out_data, 8'h00);
    step();

    // Basic frames, SEED=1
    run_frame(8'hFF, 8'hFF, "ff", 0);
    run_frame(8'h00, 8'h7F, "00", 0);
    run_frame(8'hAA, 8'h80, "aa", 0);
    run_frame(8'h0F, 8'h77, "0f", 0);

    // Backpressure for 20 cycles with an ignored in_valid pulse
    run_frame(8'h0F, 8'h77, "bp", 20);

    // Back-to-back frames with in_valid held high
    in_data  = 8'h00;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int e = 0; e < 30; e++) begin
      if (in_ready && in_valid) acc_e.push_back(e);
      if (out_valid) outs.push_back(out_data);
      step();
      if (acc_e.size() == 1) in_data = 8'hFF;
      if (acc_e.size() == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check_eq("b2b_accept_count", acc_e.size(), 2);
    if (acc_e.size() == 2) begin
      // Frame done at E10 handshake; next accept on E11 = E(W+3).
      check_eq("b2b_accept_spacing", acc_e[1] - acc_e[0], 11);
    end
    check_eq("b2b_out_count", outs.size(), 2);
    if (outs.size() == 2) begin
      check_eq("b2b_out0", outs[0], 8'h7F);
      check_eq("b2b_out1", outs[1], 8'hFF);
    end

    // Mid-frame reset at E4
    in_data  = 8'h3C;
    in_valid = 1'b1;
    step();                       // E0
    in_valid = 1'b0;
    repeat (3) step();            // E1..E3
    check_eq("mid_busy_before", busy, 1);
    rst = 1'b1;
    step();                       // E4 with reset
    rst = 1'b0;
    check_eq("mid_in_ready", in_ready, 1);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_out_valid", out_valid, 0);
    check_eq("mid_out_data", out_data, 8'h00);
    check_eq("mid_ser_din", ser_din, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("mid_no_valid", out_valid, 0);
    end
    run_frame(8'hAA, 8'h80, "post_rst_aa", 0);

    // SEED=0 instance
    run_frame0(8'h00, 8'hFF, "s0_00");
    run_frame0(8'hFF, 8'h7F, "s0_ff");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
